// File: rtl/cpu_defs.sv
// Shared core definitions.
// Purpose: word width, reset PC, and the fetch-queue entry layout used by the
// fetch stage and the instruction fetch buffer.
// Contents:
//   WORD_W        - architectural word width (32)
//   RESET_PC      - PC the fetch stage starts from after reset
//   fetch_entry_t - one queued fetch result: {pc, inst}
package cpu_defs;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the fetch buffer.
// Purpose: DEPTH x W registers, synchronous write, asynchronous read,
// cleared to zero by the asynchronous active-low reset.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset, clears every entry
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is cleared on reset so the head outputs are never X, even while
  // the queue is empty and they are otherwise don't-care.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer between the I-cache fetch port and decode.
// Purpose: circular queue of DEPTH {pc, inst} entries decoupling one-word-per-
// cycle refill from a decode stage that may stall. A flush (branch/exception
// redirect) empties the queue in one cycle.
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   flush              - discard all entries; beats push and pop
//   in_valid/in_ready  - fetch-side handshake
//   in_pc, in_inst     - presented word
//   out_valid/out_ready- decode-side handshake
//   out_pc, out_inst   - head entry (combinational from storage)
//   count              - occupancy, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid with ready low keeps its data stable;
// ready never depends combinationally on the partner's valid or ready.
module inst_fetch_buf
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_inst,
  output logic [AW:0]       count
);

  localparam int            EW       = $bits(fetch_entry_t);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  rd_entry;

  // Full/empty come from the counter alone, so in_ready has no path from
  // out_ready: a full queue refuses a word even while it is being popped.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign wr_entry.pc   = in_pc;
  assign wr_entry.inst = in_inst;

  // The word presented during a flush is dropped, so it is not written either.
  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .we     (push & ~flush),
    .waddr  (wr_ptr),
    .wdata  (wr_entry),
    .raddr  (rd_ptr),
    .rdata  (rd_entry)
  );

  assign out_pc   = rd_entry.pc;
  assign out_inst = rd_entry.inst;
  assign count    = cnt;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Testbench for inst_fetch_buf.
// Inputs change 1 ns after the rising edge; the scoreboard samples at the
// falling edge, where inputs and outputs are stable for the next rising edge.
module tb_inst_fetch_buf;
  import cpu_defs::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic              clk;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_inst;
  logic [AW:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected queue contents, {pc, inst}, oldest first.
  logic [63:0] exp_q[$];

  inst_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = $urandom();
    out_ready = rdy;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  // Checks flags and the head against the expected queue, then applies the
  // transfer the coming rising edge will perform.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      check("sb_count", 64'(count), 64'(exp_q.size()));
      check("sb_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("sb_in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        check("sb_head", {out_pc, out_inst}, exp_q[0]);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        logic do_push;
        do_push = in_valid && (exp_q.size() < DEPTH);
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({in_pc, in_inst});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    in_pc  = '0;
    in_inst = '0;
    idle();

    // Reset held for 3 cycles, then released away from the edge.
    repeat (3) tick();
    resetn = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);

    // Fill with decode stalled.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, RESET_PC + 32'(4 * i), 1'b0);
      tick();
      check("fill_count", 64'(count), 64'(i + 1));
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_pc", 64'(out_pc), 64'(RESET_PC));
    // A fifth word is held off.
    drive(1'b1, RESET_PC + 32'h10, 1'b0);
    tick();
    check("held_count", 64'(count), 64'd4);
    // Drain in order, one per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      tick();
      check("drain_count", 64'(count), 64'(DEPTH - 1 - i));
    end
    check("drained_out_valid", 64'(out_valid), 64'd0);

    // Streaming: occupancy stays at one, pointers wrap five times.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(4 * i), 1'b1);
      tick();
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(out_pc), 64'(32'h0000_1000 + 32'(4 * i)));
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("stream_end_count", 64'(count), 64'd0);

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(4 * i), 1'b0);
      tick();
    end
    check("pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, 32'hDEAD_0000, 1'b1);
    flush = 1'b1;
    tick();
    idle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("flush_stays_empty", 64'(out_valid), 64'd0);

    // Full with pop: no push that cycle, pending word taken the next.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b0);
      tick();
    end
    check("fp_full_count", 64'(count), 64'd4);
    drive(1'b1, 32'h0000_3010, 1'b1);
    tick();
    check("fp_pop_count", 64'(count), 64'd3);
    check("fp_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    tick();
    check("fp_push_count", 64'(count), 64'd4);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      tick();
    end
    check("fp_drained", 64'(count), 64'd0);

    // Mid-operation asynchronous reset.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_4000 + 32'(4 * i), 1'b0);
      tick();
    end
    idle();
    check("pre_rst_count", 64'(count), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_head", {out_pc, out_inst}, 64'd0);
    repeat (2) tick();
    resetn = 1'b1;

    // First push right after reset release.
    drive(1'b1, RESET_PC, 1'b0);
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_pc", 64'(out_pc), 64'(RESET_PC));
    drive(1'b0, 32'h0, 1'b1);
    tick();
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
